// File: rtl/spi_bridge_pkg.sv
// rtl/spi_bridge_pkg.sv - shared types and constants for the SPI register bridge
//   state_t         : bridge FSM states
//   CMD_RW_BIT      : command byte bit selecting read (1) or write (0)
//   DEF_STATUS_BYTE : default reply byte when no read data is pending
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  localparam int         CMD_RW_BIT      = 7;
  localparam logic [7:0] DEF_STATUS_BYTE = 8'hA5;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop single-bit synchronizer
//   clk : destination clock
//   rst : synchronous active-high reset, loads RESET_VAL into both flops
//   d   : asynchronous input
//   q   : synchronized output
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI byte stream to register bus command decoder
//   clk, rst           : system clock, synchronous active-high reset
//   ss                 : raw SPI slave select (active low, asynchronous)
//   byte_done, byte_rx : received-byte pulse and byte from the SPI slave
//   byte_tx            : reply byte sampled by the slave at frame start and byte end
//   reg_addr, reg_wdata, reg_we, reg_re, reg_rdata : register bus
//   frame_act          : high while the synchronized ss is low
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = DEF_STATUS_BYTE,
  parameter bit         AUTO_INC    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ss,
  input  logic              byte_done,
  input  logic [7:0]        byte_rx,
  output logic [7:0]        byte_tx,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              frame_act
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t state;
  state_t state_nx;
  logic   ss_s;
  logic   ss_s_d;
  logic   ss_rise;
  logic   we_nx;
  logic   re_nx;
  logic   re_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_ss_sync (
    .clk (clk),
    .rst (rst),
    .d   (ss),
    .q   (ss_s)
  );

  always_ff @(posedge clk) begin
    if (rst) ss_s_d <= 1'b1;
    else     ss_s_d <= ss_s;
  end

  assign ss_rise   = ss_s & ~ss_s_d;
  assign frame_act = ~ss_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: frame end always wins, a coincident byte is still strobed
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (byte_done) state_nx = byte_rx[CMD_RW_BIT] ? RD : WR;
      default: state_nx = state;
    endcase
    if (ss_rise) state_nx = IDLE;
  end

  // Strobe requests for the next cycle; a read command prefetches at once
  always_comb begin
    we_nx = 1'b0;
    re_nx = 1'b0;
    case (state)
      IDLE:    re_nx = byte_done & byte_rx[CMD_RW_BIT];
      WR:      we_nx = byte_done;
      RD:      re_nx = byte_done;
      default: begin
        we_nx = 1'b0;
        re_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      re_d      <= 1'b0;
      reg_wdata <= 8'h00;
      reg_addr  <= '0;
      byte_tx   <= STATUS_BYTE;
    end else begin
      reg_we <= we_nx;
      reg_re <= re_nx;
      re_d   <= reg_re;
      if (we_nx) reg_wdata <= byte_rx;

      // A strobe owed across frame end keeps the address for one more cycle,
      // then clears it; otherwise frame end clears it immediately.
      if (state == IDLE && byte_done && (!ss_rise || re_nx))
        reg_addr <= byte_rx[ADDR_W-1:0];
      else if (ss_rise && !(we_nx || re_nx))
        reg_addr <= '0;
      else if ((reg_we || reg_re) && state == IDLE)
        reg_addr <= '0;
      else if ((reg_we || reg_re) && AUTO_INC)
        reg_addr <= reg_addr + ADDR_ONE;

      // Read data landing after the frame has ended is dropped
      if (ss_rise)
        byte_tx <= STATUS_BYTE;
      else if (re_d && state == RD)
        byte_tx <= reg_rdata;
    end
  end

endmodule
